// File: rtl/inst_fetch_pkg.sv
// Shared types and constants for the instruction fetch unit and its prefetch FIFO.
package inst_fetch_pkg;

  localparam logic [31:0] NOP = 32'h0000_0013;
  localparam int FETCH_ENTRY_W = 64;

  typedef enum logic {
    FETCH = 1'b0,
    DRAIN = 1'b1
  } fetch_state_t;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } fetch_entry_t;

  function automatic logic [31:0] byteswap32(input logic [31:0] word);
    return {word[7:0], word[15:8], word[23:16], word[31:24]};
  endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Prefetch queue: synchronous FIFO with push, pop, flush and a combinational head.
module fetch_fifo
  import inst_fetch_pkg::*;
#(
  parameter int DEPTH = 2,
  parameter int W     = FETCH_ENTRY_W
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       push,
  input  logic [W-1:0]               push_data,
  input  logic                       pop,
  input  logic                       flush,
  output logic [W-1:0]               head,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       full,
  output logic                       empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  assign empty   = (count == '0);
  assign full    = (count == CW'(DEPTH));
  assign do_pop  = pop & ~empty;
  // A push into a full queue is only legal when the head leaves in the same cycle.
  assign do_push = push & (~full | do_pop);
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !flush) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/inst_fetch.sv
// Instruction fetch: sequential I-cache requests, stall hold, prefetch queue, redirect flush.
// Define INSTR_BYTESWAP_EN to byte-reverse cache data before it is queued.
module inst_fetch
  import inst_fetch_pkg::*;
#(
  parameter int          DEPTH    = 2,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        ICACHE_ren,
  output logic [29:0] ICACHE_addr,
  input  logic [31:0] ICACHE_rdata,
  input  logic        ICACHE_stall,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  input  logic        id_ready,
  output logic        instr_valid,
  output logic [31:0] instr,
  output logic [31:0] instr_pc
);

  localparam int CW = $clog2(DEPTH) + 1;

  fetch_state_t  state;
  logic [31:0]   fetch_pc;
  logic          hold;
  logic [29:0]   req_addr;

  logic [CW-1:0] count;
  logic          fifo_full;
  logic          fifo_empty;
  fetch_entry_t  head;
  fetch_entry_t  push_entry;
  logic [31:0]   fetch_data;

  logic          pop;
  logic          fifo_pop;
  logic          push;
  logic          complete;
  logic          stalled;
  logic          room;

  assign instr_valid = (count != '0);
  assign pop         = instr_valid & id_ready;
  assign fifo_pop    = pop & ~redirect;
  assign room        = (count < CW'(DEPTH)) | pop;

  assign ICACHE_ren  = rst_n & (hold | ((state == FETCH) & room));
  assign ICACHE_addr = hold ? req_addr : fetch_pc[31:2];

  assign stalled     = ICACHE_ren & ICACHE_stall;
  assign complete    = ICACHE_ren & ~ICACHE_stall;
  assign push        = complete & (state == FETCH) & ~redirect;

`ifdef INSTR_BYTESWAP_EN
  assign fetch_data = byteswap32(ICACHE_rdata);
`else
  assign fetch_data = ICACHE_rdata;
`endif

  assign push_entry.pc    = {ICACHE_addr, 2'b00};
  assign push_entry.instr = fetch_data;

  assign instr    = instr_valid ? head.instr : NOP;
  assign instr_pc = instr_valid ? head.pc    : 32'h0000_0000;

  // Any request still stalled at a redirect is stale and must be drained, not queued.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= FETCH;
      fetch_pc <= RESET_PC;
      hold     <= 1'b0;
      req_addr <= '0;
    end else begin
      hold <= stalled;
      if (stalled) req_addr <= ICACHE_addr;

      if (redirect)  fetch_pc <= {redirect_pc[31:2], 2'b00};
      else if (push) fetch_pc <= fetch_pc + 32'd4;

      case (state)
        FETCH: if (redirect && stalled) state <= DRAIN;
        DRAIN: if (complete)            state <= FETCH;
        default:                        state <= FETCH;
      endcase
    end
  end

  fetch_fifo #(
    .DEPTH (DEPTH),
    .W     (FETCH_ENTRY_W)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (push),
    .push_data (push_entry),
    .pop       (fifo_pop),
    .flush     (redirect),
    .head      (head),
    .count     (count),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

endmodule

// File: tb/tb_inst_fetch.sv
// Scoreboard bench for inst_fetch: directed cycle sequences, expected PCs queued at stimulus time.
module tb_inst_fetch;

  localparam logic [31:0] NOP_W = 32'h0000_0013;

  logic        clk;
  logic        rst_n;
  logic        ICACHE_ren;
  logic [29:0] ICACHE_addr;
  logic [31:0] ICACHE_rdata;
  logic        ICACHE_stall;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        id_ready;
  logic        instr_valid;
  logic [31:0] instr;
  logic [31:0] instr_pc;

  int num_checks = 0;
  int num_fails  = 0;
  logic [63:0] exp_q[$];

  inst_fetch #(
    .DEPTH    (2),
    .RESET_PC (32'h0000_0000)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .ICACHE_ren   (ICACHE_ren),
    .ICACHE_addr  (ICACHE_addr),
    .ICACHE_rdata (ICACHE_rdata),
    .ICACHE_stall (ICACHE_stall),
    .redirect     (redirect),
    .redirect_pc  (redirect_pc),
    .id_ready     (id_ready),
    .instr_valid  (instr_valid),
    .instr        (instr),
    .instr_pc     (instr_pc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Cache image: every word carries its own address so a skipped or repeated fetch shows up.
  function automatic logic [31:0] cache_word(input logic [29:0] waddr);
    return {waddr, 2'b11} ^ 32'hA5C3_0000;
  endfunction

  function automatic logic [31:0] expected_instr(input logic [31:0] pc);
    logic [31:0] w;
    w = cache_word(pc[31:2]);
`ifdef INSTR_BYTESWAP_EN
    return {w[7:0], w[15:8], w[23:16], w[31:24]};
`else
    return w;
`endif
  endfunction

  assign ICACHE_rdata = cache_word(ICACHE_addr);

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    num_checks++;
    if (actual !== expected) begin
      num_fails++;
      $display("[TB] FAIL %s: got %h, expected %h (t=%0t)", name, actual, expected, $time);
    end
  endtask

  task automatic expectStream(input logic [31:0] start_pc, input int n);
    logic [31:0] pc;
    exp_q.delete();
    pc = {start_pc[31:2], 2'b00};
    for (int i = 0; i < n; i++) begin
      exp_q.push_back({pc, expected_instr(pc)});
      pc = pc + 32'd4;
    end
  endtask

  // One cycle: drive just after the rising edge, return at the falling edge for checks.
  task automatic applyStimulus(input logic rdy, input logic stl, input logic redir, input logic [31:0] rpc);
    @(posedge clk);
    #1;
    id_ready     = rdy;
    ICACHE_stall = stl;
    redirect     = redir;
    redirect_pc  = rpc;
    if (redir) expectStream(rpc, 16);
    @(negedge clk);
  endtask

  // Monitor: every accepted instruction must be the next one on the scoreboard.
  initial begin
    logic [63:0] e;
    forever begin
      @(negedge clk);
      if (rst_n && instr_valid && id_ready && !redirect) begin
        if (exp_q.size() == 0) begin
          num_checks++;
          num_fails++;
          $display("[TB] FAIL mon_unexpected: got pc %h, expected no output", instr_pc);
        end else begin
          e = exp_q.pop_front();
          checkOutput("mon_pc", instr_pc, e[63:32]);
          checkOutput("mon_instr", instr, e[31:0]);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    rst_n        = 1'b0;
    id_ready     = 1'b0;
    ICACHE_stall = 1'b0;
    redirect     = 1'b0;
    redirect_pc  = 32'h0;

    #3;
    checkOutput("rst_ren",   32'(ICACHE_ren),  32'd0);
    checkOutput("rst_valid", 32'(instr_valid), 32'd0);
    checkOutput("rst_instr", instr,            NOP_W);
    checkOutput("rst_pc",    instr_pc,         32'h0);

    // Release reset and stream straight-line code.
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n    = 1'b1;
    id_ready = 1'b1;
    expectStream(32'h0, 16);
    @(negedge clk);
    checkOutput("c0_ren",   32'(ICACHE_ren),  32'd1);
    checkOutput("c0_addr",  32'(ICACHE_addr), 32'h0);
    checkOutput("c0_valid", 32'(instr_valid), 32'd0);

    applyStimulus(1, 0, 0, 0);
    checkOutput("c1_valid", 32'(instr_valid), 32'd1);
    checkOutput("c1_pc",    instr_pc,         32'h0);
    checkOutput("c1_addr",  32'(ICACHE_addr), 32'h1);
    applyStimulus(1, 0, 0, 0);
    checkOutput("c2_pc", instr_pc, 32'h4);
    applyStimulus(1, 0, 0, 0);
    checkOutput("c3_pc", instr_pc, 32'h8);

    // Cache stall on byte address 0x10 for three cycles.
    applyStimulus(1, 1, 0, 0);
    checkOutput("stall_c4_ren",  32'(ICACHE_ren),  32'd1);
    checkOutput("stall_c4_addr", 32'(ICACHE_addr), 32'h4);
    checkOutput("stall_c4_pc",   instr_pc,         32'hC);
    for (int i = 0; i < 2; i++) begin
      applyStimulus(1, 1, 0, 0);
      checkOutput("stall_ren",   32'(ICACHE_ren),  32'd1);
      checkOutput("stall_addr",  32'(ICACHE_addr), 32'h4);
      checkOutput("stall_valid", 32'(instr_valid), 32'd0);
    end
    applyStimulus(1, 0, 0, 0);
    checkOutput("stall_rel_ren",  32'(ICACHE_ren),  32'd1);
    checkOutput("stall_rel_addr", 32'(ICACHE_addr), 32'h4);
    applyStimulus(1, 0, 0, 0);
    checkOutput("post_stall_pc",   instr_pc,         32'h10);
    checkOutput("post_stall_addr", 32'(ICACHE_addr), 32'h5);

    // Backpressure: queue fills, requests stop, head holds.
    applyStimulus(0, 0, 0, 0);
    checkOutput("bp_c9_ren", 32'(ICACHE_ren), 32'd1);
    checkOutput("bp_c9_pc",  instr_pc,        32'h14);
    for (int i = 0; i < 4; i++) begin
      applyStimulus(0, 0, 0, 0);
      checkOutput("bp_full_ren",   32'(ICACHE_ren),  32'd0);
      checkOutput("bp_full_valid", 32'(instr_valid), 32'd1);
      checkOutput("bp_full_pc",    instr_pc,         32'h14);
    end
    applyStimulus(1, 0, 0, 0);
    checkOutput("bp_rel_ren",  32'(ICACHE_ren),  32'd1);
    checkOutput("bp_rel_addr", 32'(ICACHE_addr), 32'h7);
    applyStimulus(1, 0, 0, 0);
    checkOutput("bp_rel_pc", instr_pc, 32'h18);

    // Redirect with a full queue (0x1C, 0x20); low target bits must be ignored.
    applyStimulus(0, 0, 0, 0);
    checkOutput("pre_redir_pc", instr_pc, 32'h1C);
    applyStimulus(1, 0, 1, 32'h0000_0103);
    applyStimulus(1, 0, 0, 0);
    checkOutput("redir_valid", 32'(instr_valid), 32'd0);
    checkOutput("redir_addr",  32'(ICACHE_addr), 32'h40);
    applyStimulus(1, 0, 0, 0);
    checkOutput("redir_first_valid", 32'(instr_valid), 32'd1);
    checkOutput("redir_first_pc",    instr_pc,         32'h100);

    // Redirect while the request for byte address 0x108 is stalled.
    applyStimulus(1, 1, 0, 0);
    checkOutput("rs_issue_addr", 32'(ICACHE_addr), 32'h42);
    applyStimulus(1, 1, 1, 32'h0000_0200);
    checkOutput("rs_redir_valid", 32'(instr_valid), 32'd0);
    applyStimulus(1, 1, 0, 0);
    checkOutput("rs_drain_ren",   32'(ICACHE_ren),  32'd1);
    checkOutput("rs_drain_addr",  32'(ICACHE_addr), 32'h42);
    checkOutput("rs_drain_valid", 32'(instr_valid), 32'd0);
    applyStimulus(1, 0, 0, 0);
    checkOutput("rs_drop_addr", 32'(ICACHE_addr), 32'h42);
    applyStimulus(1, 0, 0, 0);
    checkOutput("rs_new_ren",   32'(ICACHE_ren),  32'd1);
    checkOutput("rs_new_addr",  32'(ICACHE_addr), 32'h80);
    checkOutput("rs_new_valid", 32'(instr_valid), 32'd0);
    applyStimulus(1, 0, 0, 0);
    checkOutput("rs_first_pc", instr_pc, 32'h200);

    // Reset in the middle of a stalled request.
    applyStimulus(0, 1, 0, 0);
    checkOutput("mr_pre_pc", instr_pc, 32'h204);
    applyStimulus(0, 1, 0, 0);
    checkOutput("mr_hold_ren",  32'(ICACHE_ren),  32'd1);
    checkOutput("mr_hold_addr", 32'(ICACHE_addr), 32'h82);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("mr_ren",   32'(ICACHE_ren),  32'd0);
    checkOutput("mr_valid", 32'(instr_valid), 32'd0);
    checkOutput("mr_instr", instr,            NOP_W);
    checkOutput("mr_pc",    instr_pc,         32'h0);
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n        = 1'b1;
    ICACHE_stall = 1'b0;
    id_ready     = 1'b1;
    expectStream(32'h0, 16);
    @(negedge clk);
    checkOutput("mr_rel_ren",  32'(ICACHE_ren),  32'd1);
    checkOutput("mr_rel_addr", 32'(ICACHE_addr), 32'h0);
    applyStimulus(1, 0, 0, 0);
    checkOutput("mr_first_pc", instr_pc, 32'h0);
    applyStimulus(1, 0, 0, 0);
    checkOutput("mr_second_pc", instr_pc, 32'h4);
    applyStimulus(0, 0, 0, 0);
    applyStimulus(0, 0, 0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", num_checks, num_fails);
    $finish;
  end

endmodule
